// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared 64-bit tagged memory bus (I-cache vs D-cache).
// Optional `ARB_DCACHE_PRIORITY_EN: D-cache always wins a tie instead of round-robin.
module mem_bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BURST_BEATS    = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      ic_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] ic_req,
    input  logic [BUS_TAG_WIDTH-1:0]  ic_reqtag,
    output logic                      ic_reqack,
    output logic                      ic_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] ic_resp,
    output logic [BUS_TAG_WIDTH-1:0]  ic_resptag,
    input  logic                      ic_respack,

    input  logic                      dc_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] dc_req,
    input  logic [BUS_TAG_WIDTH-1:0]  dc_reqtag,
    output logic                      dc_reqack,
    output logic                      dc_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] dc_resp,
    output logic [BUS_TAG_WIDTH-1:0]  dc_resptag,
    input  logic                      dc_respack,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,

    output logic                      busy,
    output logic                      grant_dc
);

    localparam int CNT_W = $clog2(BURST_BEATS) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WDATA = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifndef ARB_DCACHE_PRIORITY_EN
    logic               last_grant_q, last_grant_d;
`endif

    logic                      sel_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] sel_req;
    logic [BUS_TAG_WIDTH-1:0]  sel_reqtag;
    logic                      sel_respack;
    logic                      req_xfer;
    logic                      resp_xfer;
    logic                      last_beat;
    logic [CNT_W-1:0]          cnt_inc;
    logic                      pick_dc;

    // Granted requester's side of the handshake, selected by the registered grant.
    assign sel_reqcyc  = grant_q ? dc_reqcyc  : ic_reqcyc;
    assign sel_req     = grant_q ? dc_req     : ic_req;
    assign sel_reqtag  = grant_q ? dc_reqtag  : ic_reqtag;
    assign sel_respack = grant_q ? dc_respack : ic_respack;

    assign req_xfer  = sel_reqcyc && bus_reqack;
    assign resp_xfer = bus_respcyc && sel_respack;
    assign last_beat = (cnt_q == CNT_W'(BURST_BEATS - 1));
    // Saturate rather than wrap so a stray extra beat can never restart the count.
    assign cnt_inc   = (cnt_q == CNT_W'(BURST_BEATS)) ? cnt_q : cnt_q + 1'b1;

`ifdef ARB_DCACHE_PRIORITY_EN
    assign pick_dc = dc_reqcyc;
`else
    assign pick_dc = (ic_reqcyc && dc_reqcyc) ? ~last_grant_q : dc_reqcyc;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
`ifndef ARB_DCACHE_PRIORITY_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
`ifndef ARB_DCACHE_PRIORITY_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default first,
    // otherwise paths that skip the assignment infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
`ifndef ARB_DCACHE_PRIORITY_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (ic_reqcyc || dc_reqcyc) begin
                    grant_d      = pick_dc;
`ifndef ARB_DCACHE_PRIORITY_EN
                    last_grant_d = pick_dc;
`endif
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (req_xfer) begin
                    cnt_d   = '0;
                    state_d = sel_reqtag[BUS_TAG_WIDTH-1] ? S_WDATA : S_RESP;
                end
            end
            S_WDATA: begin
                if (req_xfer) begin
                    cnt_d = cnt_inc;
                    if (last_beat) state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (resp_xfer) begin
                    cnt_d = cnt_inc;
                    if (last_beat) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        ic_reqack   = 1'b0;
        dc_reqack   = 1'b0;
        ic_respcyc  = 1'b0;
        ic_resp     = '0;
        ic_resptag  = '0;
        dc_respcyc  = 1'b0;
        dc_resp     = '0;
        dc_resptag  = '0;
        busy        = (state_q != S_IDLE);
        grant_dc    = grant_q;
        unique case (state_q)
            S_REQ, S_WDATA: begin
                bus_reqcyc = sel_reqcyc;
                bus_req    = sel_req;
                bus_reqtag = sel_reqtag;
                if (grant_q) dc_reqack = bus_reqack;
                else         ic_reqack = bus_reqack;
            end
            S_RESP: begin
                bus_respack = sel_respack;
                if (grant_q) begin
                    dc_respcyc = bus_respcyc;
                    dc_resp    = bus_resp;
                    dc_resptag = bus_resptag;
                end else begin
                    ic_respcyc = bus_respcyc;
                    ic_resp    = bus_resp;
                    ic_resptag = bus_resptag;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table plus hand-written write and reset sequences.
// Honours `ARB_DCACHE_PRIORITY_EN for the tie-break expectations.
module tb_mem_bus_arbiter;

    localparam logic [12:0] IC_TAG  = 13'h0001;
    localparam logic [12:0] DC_TAG  = 13'h0002;
    localparam logic [12:0] RSP_TAG = 13'h0ABC;
    localparam logic [63:0] IC_DATA = 64'h1C1C;
    localparam logic [63:0] DC_DATA = 64'hDCDC;
`ifdef ARB_DCACHE_PRIORITY_EN
    localparam logic G1 = 1'b1;
    localparam logic G2 = 1'b1;
`else
    localparam logic G1 = 1'b0;
    localparam logic G2 = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_reqcyc, ic_reqack, ic_respcyc, ic_respack;
    logic [63:0] ic_req, ic_resp;
    logic [12:0] ic_reqtag, ic_resptag;
    logic        dc_reqcyc, dc_reqack, dc_respcyc, dc_respack;
    logic [63:0] dc_req, dc_resp;
    logic [12:0] dc_reqtag, dc_resptag;
    logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [63:0] bus_req, bus_resp;
    logic [12:0] bus_reqtag, bus_resptag;
    logic        busy, grant_dc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_reqcyc(ic_reqcyc), .ic_req(ic_req), .ic_reqtag(ic_reqtag), .ic_reqack(ic_reqack),
        .ic_respcyc(ic_respcyc), .ic_resp(ic_resp), .ic_resptag(ic_resptag), .ic_respack(ic_respack),
        .dc_reqcyc(dc_reqcyc), .dc_req(dc_req), .dc_reqtag(dc_reqtag), .dc_reqack(dc_reqack),
        .dc_respcyc(dc_respcyc), .dc_resp(dc_resp), .dc_resptag(dc_resptag), .dc_respack(dc_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack),
        .busy(busy), .grant_dc(grant_dc)
    );

    typedef struct {
        logic        ic_cyc, dc_cyc, bus_ack, rsp_cyc, rack;
        logic [63:0] rsp_data;
        logic        busy, gnt, b_cyc, ic_ack, dc_ack, ic_rcyc, dc_rcyc, b_rack;
        logic [12:0] b_tag;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk_idle(input logic ic, input logic dc);
        vec_t v = '{default: '0};
        v.ic_cyc = ic;
        v.dc_cyc = dc;
        return v;
    endfunction

    function automatic vec_t mk_req(input logic ic, input logic dc, input logic ack, input logic g);
        vec_t v = '{default: '0};
        v.ic_cyc  = ic;
        v.dc_cyc  = dc;
        v.bus_ack = ack;
        v.busy    = 1'b1;
        v.gnt     = g;
        v.b_cyc   = 1'b1;
        v.b_tag   = g ? DC_TAG : IC_TAG;
        v.ic_ack  = ack & ~g;
        v.dc_ack  = ack & g;
        return v;
    endfunction

    function automatic vec_t mk_beat(input logic ic, input logic dc, input logic g,
                                     input logic [63:0] data, input logic rack);
        vec_t v = '{default: '0};
        v.ic_cyc   = ic;
        v.dc_cyc   = dc;
        v.rsp_cyc  = 1'b1;
        v.rsp_data = data;
        v.rack     = rack;
        v.busy     = 1'b1;
        v.gnt      = g;
        v.ic_rcyc  = ~g;
        v.dc_rcyc  = g;
        v.b_rack   = rack;
        return v;
    endfunction

    task automatic build_table();
        // Two back-to-back ties with both requesters held high.
        vecs.push_back(mk_idle(1, 1));
        vecs.push_back(mk_req(1, 1, 1, G1));
        for (int i = 0; i < 8; i++) vecs.push_back(mk_beat(1, 1, G1, 64'h20 + 64'(i), 1));
        vecs.push_back(mk_idle(1, 1));
        vecs.push_back(mk_req(1, 1, 1, G2));
        for (int i = 0; i < 8; i++) vecs.push_back(mk_beat(1, 1, G2, 64'h30 + 64'(i), 1));
        vecs.push_back(mk_idle(0, 0));
        // Single I-cache read with one bus stall on the request beat.
        vecs.push_back(mk_idle(1, 0));
        vecs.push_back(mk_req(1, 0, 0, 0));
        vecs.push_back(mk_req(1, 0, 1, 0));
        for (int i = 0; i < 8; i++) vecs.push_back(mk_beat(0, 0, 0, 64'h10 + 64'(i), 1));
        vecs.push_back(mk_idle(0, 0));
        // I-cache read with three cycles of response backpressure after beat 4.
        vecs.push_back(mk_idle(1, 0));
        vecs.push_back(mk_req(1, 0, 1, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk_beat(0, 0, 0, 64'h40 + 64'(i), 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk_beat(0, 0, 0, 64'h44, 0));
        for (int i = 4; i < 8; i++) vecs.push_back(mk_beat(0, 0, 0, 64'h40 + 64'(i), 1));
        vecs.push_back(mk_idle(0, 0));
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            ic_reqcyc   = vecs[i].ic_cyc;
            dc_reqcyc   = vecs[i].dc_cyc;
            bus_reqack  = vecs[i].bus_ack;
            bus_respcyc = vecs[i].rsp_cyc;
            bus_resp    = vecs[i].rsp_data;
            ic_respack  = vecs[i].rack;
            dc_respack  = vecs[i].rack;
            #1;
            check($sformatf("row%0d busy", i), busy, vecs[i].busy);
            if (vecs[i].busy) check($sformatf("row%0d grant_dc", i), grant_dc, vecs[i].gnt);
            check($sformatf("row%0d bus_reqcyc", i), bus_reqcyc, vecs[i].b_cyc);
            check($sformatf("row%0d bus_reqtag", i), bus_reqtag, vecs[i].b_tag);
            check($sformatf("row%0d bus_req", i), bus_req,
                  vecs[i].b_cyc ? (vecs[i].gnt ? DC_DATA : IC_DATA) : 64'h0);
            check($sformatf("row%0d ic_reqack", i), ic_reqack, vecs[i].ic_ack);
            check($sformatf("row%0d dc_reqack", i), dc_reqack, vecs[i].dc_ack);
            check($sformatf("row%0d ic_respcyc", i), ic_respcyc, vecs[i].ic_rcyc);
            check($sformatf("row%0d dc_respcyc", i), dc_respcyc, vecs[i].dc_rcyc);
            check($sformatf("row%0d ic_resp", i), ic_resp, vecs[i].ic_rcyc ? vecs[i].rsp_data : 64'h0);
            check($sformatf("row%0d dc_resp", i), dc_resp, vecs[i].dc_rcyc ? vecs[i].rsp_data : 64'h0);
            check($sformatf("row%0d ic_resptag", i), ic_resptag, vecs[i].ic_rcyc ? RSP_TAG : 13'h0);
            check($sformatf("row%0d bus_respack", i), bus_respack, vecs[i].b_rack);
            step();
        end
    endtask

    task automatic dc_write_seq();
        dc_reqcyc = 1'b1;
        dc_reqtag = 13'h1005;
        dc_req    = 64'h0;
        #1;
        check("wr idle busy", busy, 1'b0);
        step();
        bus_reqack = 1'b1;
        #1;
        check("wr req bus_reqcyc", bus_reqcyc, 1'b1);
        check("wr req bus_reqtag", bus_reqtag, 13'h1005);
        check("wr req grant_dc", grant_dc, 1'b1);
        check("wr req dc_reqack", dc_reqack, 1'b1);
        check("wr req ic_reqack", ic_reqack, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            dc_req = 64'hA0 + 64'(i);
            if (i == 3) begin
                bus_reqack = 1'b0;
                #1;
                check("wr stall dc_reqack", dc_reqack, 1'b0);
                check("wr stall busy", busy, 1'b1);
                step();
            end
            bus_reqack  = 1'b1;
            bus_respcyc = 1'b1;
            dc_respack  = 1'b1;
            ic_respack  = 1'b1;
            #1;
            check($sformatf("wr beat%0d bus_req", i), bus_req, 64'hA0 + 64'(i));
            check($sformatf("wr beat%0d bus_reqcyc", i), bus_reqcyc, 1'b1);
            check($sformatf("wr beat%0d dc_reqack", i), dc_reqack, 1'b1);
            check($sformatf("wr beat%0d dc_respcyc", i), dc_respcyc, 1'b0);
            check($sformatf("wr beat%0d ic_respcyc", i), ic_respcyc, 1'b0);
            check($sformatf("wr beat%0d bus_respack", i), bus_respack, 1'b0);
            step();
        end
        dc_reqcyc   = 1'b0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        #1;
        check("wr done busy", busy, 1'b0);
        check("wr done dc_respcyc", dc_respcyc, 1'b0);
        step();
    endtask

    task automatic ic_read_prefix(input int beats, input logic [63:0] base);
        ic_reqcyc = 1'b1;
        ic_reqtag = IC_TAG;
        ic_req    = IC_DATA;
        #1;
        check("rd idle busy", busy, 1'b0);
        step();
        bus_reqack = 1'b1;
        #1;
        check("rd req bus_reqcyc", bus_reqcyc, 1'b1);
        check("rd req grant_dc", grant_dc, 1'b0);
        check("rd req ic_reqack", ic_reqack, 1'b1);
        step();
        ic_reqcyc   = 1'b0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b1;
        ic_respack  = 1'b1;
        for (int i = 0; i < beats; i++) begin
            bus_resp = base + 64'(i);
            #1;
            check($sformatf("rd beat%0d ic_resp", i), ic_resp, base + 64'(i));
            check($sformatf("rd beat%0d ic_respcyc", i), ic_respcyc, 1'b1);
            step();
        end
    endtask

    task automatic reset_seq();
        ic_read_prefix(4, 64'h50);
        bus_resp = 64'h54;
        #1;
        check("rst pre busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("rst busy", busy, 1'b0);
        check("rst grant_dc", grant_dc, 1'b0);
        check("rst bus_reqcyc", bus_reqcyc, 1'b0);
        check("rst bus_respack", bus_respack, 1'b0);
        check("rst ic_respcyc", ic_respcyc, 1'b0);
        check("rst ic_resp", ic_resp, 64'h0);
        check("rst ic_resptag", ic_resptag, 13'h0);
        check("rst dc_respcyc", dc_respcyc, 1'b0);
        check("rst ic_reqack", ic_reqack, 1'b0);
        bus_respcyc = 1'b0;
        ic_respack  = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        step();
        ic_read_prefix(8, 64'h60);
        bus_respcyc = 1'b0;
        ic_respack  = 1'b0;
        #1;
        check("post-rst done busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        ic_reqcyc   = 1'b0;
        ic_req      = IC_DATA;
        ic_reqtag   = IC_TAG;
        ic_respack  = 1'b0;
        dc_reqcyc   = 1'b0;
        dc_req      = DC_DATA;
        dc_reqtag   = DC_TAG;
        dc_respack  = 1'b0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = 64'h0;
        bus_resptag = RSP_TAG;
        #12;
        check("reset busy", busy, 1'b0);
        check("reset grant_dc", grant_dc, 1'b0);
        check("reset bus_reqcyc", bus_reqcyc, 1'b0);
        check("reset bus_respack", bus_respack, 1'b0);
        reset = 1'b1;
        step();

        build_table();
        run_table();
        dc_write_seq();
        reset_seq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
